// File: rtl/store_align_unit.sv
// Store alignment unit: turns a register store into a word-aligned
// memory write with lane-replicated data, byte enables and address checks.
module store_align_unit #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        st_done,
  output logic        exc_ades,
  output logic [31:0] exc_badvaddr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  typ_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        accept;
  logic        bad;
  logic [31:0] wdata;
  logic [3:0]  be;

  assign accept = st_valid & st_ready;

  // Illegal width or address not a multiple of the access size.
  always_comb begin
    bad = 1'b0;
    unique case (st_type)
      2'b00: bad = 1'b0;
      2'b01: bad = st_addr[0];
      2'b10: bad = |st_addr[1:0];
      default: bad = 1'b1;
    endcase
  end

  // Control FSM plus capture of the accepted request and fault address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      typ_q        <= 2'b00;
      addr_q       <= '0;
      data_q       <= '0;
      exc_badvaddr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            typ_q  <= st_type;
            addr_q <= st_addr;
            data_q <= st_data;
            if (bad) begin
              state        <= ERR;
              exc_badvaddr <= st_addr;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Replicate the stored byte or halfword across every lane.
  always_comb begin
    wdata = data_q;
    unique case (typ_q)
      2'b00: wdata = {4{data_q[7:0]}};
      2'b01: wdata = {2{data_q[15:0]}};
      default: wdata = data_q;
    endcase
  end

  // Byte-lane selection; big-endian mirrors the lane order.
  always_comb begin
    be = 4'b0000;
    unique case (typ_q)
      2'b00: be = BIG_ENDIAN ? (4'b1000 >> addr_q[1:0])
                             : (4'b0001 << addr_q[1:0]);
      2'b01: be = (addr_q[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign st_ready  = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata;
  assign mem_be    = mem_req ? be : 4'b0000;
  assign st_done   = mem_req & mem_ack;
  assign exc_ades  = (state == ERR);

endmodule

// File: tb/tb_store_align_unit.sv
// Scoreboard bench for store_align_unit: little- and big-endian
// instances share stimulus and are checked against a byte-level model.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic [1:0]  st_type = 2'b00;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        mem_ack = 1'b0;

  logic        st_ready, mem_req, st_done, exc_ades;
  logic [31:0] mem_addr, mem_wdata, exc_badvaddr;
  logic [3:0]  mem_be;

  logic        st_ready_b, mem_req_b, st_done_b, exc_ades_b;
  logic [31:0] mem_addr_b, mem_wdata_b, exc_badvaddr_b;
  logic [3:0]  mem_be_b;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] badv;
    logic [3:0]  be_le;
    logic [3:0]  be_be;
  } exp_t;

  exp_t sb[$];
  time  accept_t;

  store_align_unit #(.BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_type(st_type), .st_addr(st_addr), .st_data(st_data),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .st_done(st_done),
    .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr)
  );

  store_align_unit #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready_b),
    .st_type(st_type), .st_addr(st_addr), .st_data(st_data),
    .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_be(mem_be_b),
    .mem_ack(mem_ack), .st_done(st_done_b),
    .exc_ades(exc_ades_b), .exc_badvaddr(exc_badvaddr_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Byte-level reference: which bytes of the word the store touches.
  function automatic exp_t model(input logic [1:0] t,
                                 input logic [31:0] a,
                                 input logic [31:0] d);
    exp_t e;
    int size;
    int off;
    size = 1 << t;
    off = int'(a[1:0]);
    e.err = (t == 2'b11) || ((off % size) != 0);
    e.addr = a & 32'hFFFF_FFFC;
    e.badv = a;
    e.wdata = '0;
    e.be_le = '0;
    e.be_be = '0;
    if (!e.err) begin
      for (int k = 0; k < 4; k++)
        e.wdata[8*k +: 8] = d[8*(k % size) +: 8];
      for (int j = off; j < off + size; j++) begin
        e.be_le[j] = 1'b1;
        e.be_be[3-j] = 1'b1;
      end
    end
    return e;
  endfunction

  // Monitor: compares presented writes and exceptions against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (!mem_req) chk("idle_be", {28'd0, mem_be}, 32'd0);
      if (mem_req) begin
        chk("busy_ready", {31'd0, st_ready}, 32'd0);
        chk("done_same_cycle", {31'd0, st_done}, {31'd0, mem_ack});
        if (sb.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          chk("req_kind", {31'd0, sb[0].err}, 32'd0);
          chk("mem_addr", mem_addr, sb[0].addr);
          chk("mem_wdata", mem_wdata, sb[0].wdata);
          chk("mem_be_le", {28'd0, mem_be}, {28'd0, sb[0].be_le});
          chk("mem_be_be", {28'd0, mem_be_b}, {28'd0, sb[0].be_be});
          chk("mem_wdata_be", mem_wdata_b, sb[0].wdata);
          if (st_done) void'(sb.pop_front());
        end
      end else if (st_done) begin
        chk("done_without_req", 32'd1, 32'd0);
      end
      if (exc_ades) begin
        chk("exc_no_req", {31'd0, mem_req}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_exc", 32'd1, 32'd0);
        end else begin
          chk("exc_kind", {31'd0, sb[0].err}, 32'd1);
          chk("badvaddr", exc_badvaddr, sb[0].badv);
          chk("badvaddr_be", exc_badvaddr_b, sb[0].badv);
          void'(sb.pop_front());
        end
      end
    end
  end

  // wait_ack: cycles of low mem_ack before ack; -1 aborts with reset.
  task automatic store(input logic [1:0] t,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input int wait_ack);
    exp_t e;
    int n;
    n = 0;
    e = model(t, a, d);
    st_valid = 1'b1;
    st_type = t;
    st_addr = a;
    st_data = d;
    @(negedge clk);
    while (!st_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!st_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      st_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(posedge clk);
    accept_t = $time;
    #1;
    st_valid = 1'b0;
    st_type = 2'($urandom);
    st_addr = $urandom;
    st_data = $urandom;
    chk("req_after_accept", {31'd0, mem_req}, {31'd0, !e.err});
    chk("exc_after_accept", {31'd0, exc_ades}, {31'd0, e.err});
    if (e.err) begin
      mem_ack = 1'($urandom);
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end else if (wait_ack < 0) begin
      @(posedge clk);
      #3;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_st_done", {31'd0, st_done}, 32'd0);
      chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
    end else begin
      mem_ack = 1'b0;
      repeat (wait_ack) begin
        @(posedge clk);
        #1;
      end
      mem_ack = 1'b1;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
    chk("ready_after_store", {31'd0, st_ready}, 32'd1);
  endtask

  initial begin
    time t0;
    int  w;
    #1 rst = 1'b1;
    #2;
    chk("rst_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_done", {31'd0, st_done}, 32'd0);
    chk("rst_exc", {31'd0, exc_ades}, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_badv", exc_badvaddr, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    store(2'b00, 32'h1000_0003, 32'h1122_3344, 0);
    store(2'b01, 32'h0000_0006, 32'hAAAA_BEEF, 0);
    store(2'b10, 32'h0000_0102, 32'h5555_6666, 0);
    store(2'b10, 32'h0000_0020, 32'hDEAD_BEEF, 3);
    store(2'b10, 32'h0000_0040, 32'hCAFE_F00D, -1);
    store(2'b00, 32'h0000_0001, 32'h0000_00A5, 0);
    store(2'b11, 32'h0000_0080, 32'h1234_5678, 0);
    store(2'b01, 32'h0000_0009, 32'h1234_5678, 0);

    store(2'b10, 32'h0000_0100, 32'h0101_0101, 0);
    t0 = accept_t;
    store(2'b00, 32'h0000_0102, 32'h0202_0202, 0);
    chk("b2b_interval", 32'(accept_t - t0), 32'd20);
    t0 = accept_t;
    store(2'b01, 32'h0000_0104, 32'h0303_0303, 0);
    chk("b2b_interval2", 32'(accept_t - t0), 32'd20);

    for (int i = 0; i < 60; i++) begin
      w = int'($urandom_range(0, 3));
      store(2'($urandom), $urandom, $urandom, w);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_align_unit.md
STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 The block SHALL have parameter BIG_ENDIAN, default 0, which selects the byte-lane order (0 = little-endian, 1 = big-endian).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 st_valid  input  1  SHALL mean a store request is present.
REQ-005 st_ready  output  1  SHALL mean the unit accepts a request this cycle.
REQ-006 st_type  input  2  SHALL give the store width: 00 = SB, 01 = SH, 10 = SW, 11 = illegal.
REQ-007 st_addr  input  32  SHALL be the store byte address.
REQ-008 st_data  input  32  SHALL be the register data; only its low byte or halfword is used for SB or SH.
REQ-009 mem_req  output  1  SHALL be the write request to data memory.
REQ-010 mem_addr  output  32  SHALL be the word-aligned address {addr[31:2], 2'b00}.
REQ-011 mem_wdata  output  32  SHALL be the lane-replicated write data.
REQ-012 mem_be  output  4  SHALL be the byte enables; bit i qualifies mem_wdata[8i+7:8i].
REQ-013 mem_ack  input  1  SHALL mean memory accepted the write this cycle.
REQ-014 st_done  output  1  SHALL be a one-cycle pulse when a store completes.
REQ-015 exc_ades  output  1  SHALL be a one-cycle pulse on an address-error or illegal-type store.
REQ-016 exc_badvaddr  output  32  SHALL carry the faulting st_addr, held until the next exception.

Function
REQ-017 The FSM SHALL have three states (IDLE, REQ, ERR), and st_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted when st_valid & st_ready, capturing st_type, st_addr and st_data into registers.
REQ-019 An accepted request that is aligned with a legal type SHALL go IDLE -> REQ, so mem_req rises the cycle after acceptance.
REQ-020 An accepted request that is misaligned (SH with addr[0]=1; SW with addr[1:0]!=0) or has st_type=11 SHALL go IDLE -> ERR, issue no mem_req, and set exc_badvaddr to st_addr.
REQ-021 In ERR, exc_ades SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-022 In REQ, mem_req, mem_addr, mem_wdata and mem_be SHALL be driven from the registers and held stable until mem_ack.
REQ-023 In REQ with mem_ack=1, the unit SHALL pulse st_done in the same cycle and go to IDLE; mem_ack outside REQ SHALL be ignored.
REQ-024 Write data SHALL be SB: {4{d[7:0]}}, SH: {2{d[15:0]}}, SW: d.
REQ-025 Byte enables with BIG_ENDIAN=0 SHALL be SB: 4'b0001 << a[1:0]; SH: a[1]=0 -> 0011, a[1]=1 -> 1100; SW: 1111.
REQ-026 Byte enables with BIG_ENDIAN=1 SHALL be SB: 4'b1000 >> a[1:0]; SH: a[1]=0 -> 1100, a[1]=1 -> 0011; SW: 1111.
REQ-027 Outside REQ, mem_req SHALL be 0 and mem_be SHALL be 0000.
REQ-028 Minimum store latency SHALL be: accept at cycle N, mem_req at N+1, done at N+1 if mem_ack=1, and the next accept at N+2.
REQ-029 st_valid while st_ready=0 SHALL NOT be captured; the requester holds the request.

Reset
REQ-030 While rst=1 the state SHALL be IDLE, st_ready=1, and mem_req, st_done and exc_ades SHALL be 0.
REQ-031 While rst=1, mem_be SHALL be 0000 and mem_addr, mem_wdata and exc_badvaddr SHALL be 0.
REQ-032 rst asserted mid-transaction (in REQ or ERR) SHALL immediately drop mem_req and exc_ades with no st_done, and the pending store SHALL be discarded.

Verification
REQ-033 SB, addr 0x1000_0003, data 0x1122_3344, BIG_ENDIAN=0, mem_ack the first REQ cycle -> mem_addr 0x1000_0000, mem_wdata 0x4444_4444, mem_be 1000, st_done pulsed.
REQ-034 SH, addr 0x0000_0006, data 0xAAAA_BEEF, BIG_ENDIAN=1 -> mem_wdata 0xBEEF_BEEF, mem_be 0011, mem_addr 0x0000_0004.
REQ-035 SW, addr 0x0000_0102 -> no mem_req, exc_ades one pulse, exc_badvaddr 0x0000_0102, st_ready 1 again two cycles after acceptance.
REQ-036 SW, addr 0x20, mem_ack held low 3 cycles then high -> mem_req, mem_be 1111 and mem_wdata stable for all 4 cycles, one st_done, st_ready 0 throughout.
REQ-037 rst pulsed while in REQ -> mem_req 0 asynchronously, no st_done; a following SB to 0x1 yields mem_be 0010.
REQ-038 st_type=11 at an aligned address -> exc_ades pulse and no memory access; back-to-back stores give one accept every 2 cycles when mem_ack is always 1.
